// File: rtl/cpu_pio_buttons.sv
// Avalon-MM input PIO for push-buttons and switches.
// Synchronizes, debounces, captures edges and raises a level IRQ.
module cpu_pio_buttons #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;

    assign wr_en = chipselect && !write_n;

    // Per-bit debounce: accept a bit once it has differed long enough.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = ~deb_q & deb_d;
    assign fall = deb_q & ~deb_d;

    // Select which accepted transitions get latched.
    always_comb begin
        case (EDGE_TYPE)
            0:       cap_set = rise;
            1:       cap_set = fall;
            default: cap_set = rise | fall;
        endcase
    end

    // Register writes: W1C capture (set wins) and mask load.
    always_comb begin
        cap_clr = '0;
        mask_d  = mask_q;
        if (wr_en && address == 2'd3) begin
            cap_clr = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        edge_d = (edge_q & ~cap_clr) | cap_set;
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
            deb_q   <= RESET_VALUE;
            edge_q  <= '0;
            mask_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-latency read mux, zero-extended above WIDTH.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = deb_q;
            2'd2:    readdata[WIDTH-1:0] = mask_q;
            2'd3:    readdata[WIDTH-1:0] = edge_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_q & mask_q);

endmodule

// File: doc/cpu_pio_buttons.md
Name: cpu_pio_buttons

Overview:
- Avalon-MM slave input PIO. It is the read-side counterpart of the existing single-bit output PIOs.
- Samples a WIDTH-bit external input bus (push-buttons/switches) through a 2-flop synchronizer and a per-bit debouncer.
- Latches selected edges into a write-1-to-clear edge-capture register.
- Raises a level interrupt to the Nios II CPU when any captured, unmasked bit is set.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronized bit must differ from its debounced value before it is accepted (>=1; 50000 = 1 ms at 50 MHz).
- EDGE_TYPE, 1, captured edge: 0 rising, 1 falling, 2 any.
- RESET_VALUE, all ones (WIDTH bits), reset value of the synchronizer and debounced registers. Buttons are active-low, so no spurious edge occurs after reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, synchronous, active-low.
- address  input  2  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  write strobe, active-low.
- writedata  input  32  write data; bits above WIDTH ignored.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  read data, zero-extended above WIDTH.
- irq  output  1  level interrupt request, active-high.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (reset_n). All state updates on the posedge of clk only.
- Reset (reset_n==0 at a posedge):
  - sync1, sync2 and debounced registers load RESET_VALUE.
  - Debounce counters, edgecapture and irqmask load 0.
  - Resulting outputs: irq=0; readdata at address 0 = RESET_VALUE.
  - Reset mid-debounce discards partial counts. Reset takes priority over every write or edge in the same cycle.
- Register map (read latency 0, readdata combinational from address and registers):
  - 0 data (RO): debounced value. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask (RW): per-bit interrupt enable.
  - 3 edgecapture (R/W1C): per-bit edge flags.
- A write occurs on a posedge with chipselect=1, write_n=0. There is no wait state. Reads have no side effects.
- Synchronizer: sync1<=in_port; sync2<=sync1.
- Debouncer (per bit i, counter width clog2(DEBOUNCE_CYCLES), minimum 1):
  - sync2[i]==deb[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: deb[i]<=sync2[i]; cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
- Debounce latency and filtering:
  - An input change set up before edge 1 and held appears in deb at edge 2+DEBOUNCE_CYCLES.
  - Pulses seen on sync2 for fewer than DEBOUNCE_CYCLES cycles are discarded.
  - Pulses lasting exactly DEBOUNCE_CYCLES cycles are accepted.
- Edge detection:
  - An accepted change is evaluated at the same posedge deb[i] updates: rising (old 0 -> new 1), falling (1 -> 0), any.
  - A matching change sets edgecapture[i] at that same edge.
- edgecapture clear:
  - Write to address 3 clears each bit where writedata[i]=1. Bits with writedata[i]=0 are unaffected.
  - Simultaneous set and clear on the same bit and cycle: the set wins and the bit stays 1.
- irqmask: write to address 2 loads writedata[WIDTH-1:0].
- irq = |(edgecapture & irqmask), combinational from registers.
  - Mask changes affect irq in the cycle after the write edge.
  - irq stays high until the flag is cleared or the mask bit is cleared.
- Bits are independent. Multiple bits may change or capture in the same cycle.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, RESET_VALUE=4'hF unless noted):
- Reset: hold reset_n=0 two clocks with in_port=4'hF, then release -> data reads 4'hF, edgecapture 0, irqmask 0, irq=0; address 1 reads 0.
- Clean press: drive in_port[0]=0 before edge 1 and hold -> data reads 4'hE after edge 6 (not after edge 5); edgecapture=4'h1 at edge 6; irq stays 0 (mask 0).
- Glitch reject: in_port[1] low for 3 cycles -> data unchanged, edgecapture unchanged. A 4-cycle low pulse -> accepted (data bit 1 = 0, capture bit 1 set).
- Interrupt path: write irqmask=4'h1, press bit 0 -> irq=1. Write 4'h2 to address 3 -> irq stays 1. Write 4'h1 to address 3 -> edgecapture 0, irq=0 next cycle. Release bit 0 -> no capture (falling only).
- Set/clear collision: time a write of 4'h4 to address 3 on the exact edge that bit 2 captures -> edgecapture[2]=1 afterwards.
- EDGE_TYPE=2 with RESET_VALUE=0: rise then fall on bit 3, clearing between -> capture sets on both transitions. Assert reset_n=0 mid-debounce (cnt=2) -> after release, no capture and data=0.
